// File: rtl/add_pipe.sv
// add_pipe: pipelined two's-complement adder/subtractor, CHUNK bits summed per stage,
// valid/ready handshake at both ends. Define ADD_PIPE_SAT_EN to clamp sum on signed overflow.
module add_pipe #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int STAGES = WIDTH / CHUNK;
  localparam logic [WIDTH-1:0] CHUNK_MASK = WIDTH'({CHUNK{1'b1}});

`ifdef ADD_PIPE_SAT_EN
  localparam logic [WIDTH-1:0] SAT_MIN = WIDTH'(1) << (WIDTH - 1);
  localparam logic [WIDTH-1:0] SAT_MAX = ~SAT_MIN;
`endif

  // Word w holds finished sum chunks below chunk k and still-unsummed a chunks from k up;
  // chunk k is replaced by its sum. Returns {carry_out, updated word}.
  function automatic logic [WIDTH:0] add_chunk(
    input logic [WIDTH-1:0] w,
    input logic [WIDTH-1:0] be,
    input logic             ci,
    input int               k
  );
    logic [CHUNK-1:0] a_c;
    logic [CHUNK-1:0] b_c;
    logic [CHUNK:0]   s;
    logic [WIDTH-1:0] w_new;
    a_c   = CHUNK'(w >> (k * CHUNK));
    b_c   = CHUNK'(be >> (k * CHUNK));
    s     = {1'b0, a_c} + {1'b0, b_c} + (CHUNK + 1)'(ci);
    w_new = (w & ~(CHUNK_MASK << (k * CHUNK))) | (WIDTH'(s[CHUNK-1:0]) << (k * CHUNK));
    return {s[CHUNK], w_new};
  endfunction

  logic             en;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  logic             top_v;
  logic [WIDTH-1:0] top_w;
  logic [WIDTH-1:0] top_b;
  logic             top_c;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH:0]   fin;
  logic             fin_ovf;
  logic [WIDTH-1:0] fin_sum;

  // One global advance: every stage moves together or everything holds.
  assign en       = !out_valid_q || out_ready;
  assign in_ready = en;
  assign b_eff    = sub ? ~b : b;
  assign cin_eff  = sub ? ~cin : cin;

  if (STAGES == 1) begin : g_single
    assign top_v = in_valid;
    assign top_w = a;
    assign top_b = b_eff;
    assign top_c = cin_eff;
  end else begin : g_multi
    logic [STAGES-2:0] v_q, v_d;
    logic [STAGES-2:0] c_q, c_d;
    logic [WIDTH-1:0]  w_q [STAGES-1];
    logic [WIDTH-1:0]  w_d [STAGES-1];
    logic [WIDTH-1:0]  b_q [STAGES-1];
    logic [WIDTH-1:0]  b_d [STAGES-1];

    always_comb begin
      v_d = v_q;
      c_d = c_q;
      w_d = w_q;
      b_d = b_q;
      if (en) begin
        v_d[0] = in_valid;
        {c_d[0], w_d[0]} = add_chunk(a, b_eff, cin_eff, 0);
        b_d[0] = b_eff;
        for (int k = 1; k < STAGES - 1; k++) begin
          v_d[k] = v_q[k-1];
          {c_d[k], w_d[k]} = add_chunk(w_q[k-1], b_q[k-1], c_q[k-1], k);
          b_d[k] = b_q[k-1];
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        v_q <= '0;
      end else begin
        v_q <= v_d;
      end
    end

    // Payload of invalid stages is don't-care, so it carries no reset.
    always_ff @(posedge clk) begin
      c_q <= c_d;
      w_q <= w_d;
      b_q <= b_d;
    end

    assign top_v = v_q[STAGES-2];
    assign top_w = w_q[STAGES-2];
    assign top_b = b_q[STAGES-2];
    assign top_c = c_q[STAGES-2];
  end

  always_comb begin
    fin     = add_chunk(top_w, top_b, top_c, STAGES - 1);
    fin_ovf = (top_w[WIDTH-1] == top_b[WIDTH-1]) && (fin[WIDTH-1] != top_w[WIDTH-1]);
    fin_sum = fin[WIDTH-1:0];
`ifdef ADD_PIPE_SAT_EN
    if (fin_ovf) begin
      fin_sum = top_w[WIDTH-1] ? SAT_MIN : SAT_MAX;
    end
`endif
    out_valid_d = out_valid_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    if (en) begin
      out_valid_d = top_v;
      // Output data only loads on a real result so it stays 0 after reset.
      if (top_v) begin
        sum_d  = fin_sum;
        cout_d = fin[WIDTH];
        ovf_d  = fin_ovf;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_add_pipe.sv
// tb_add_pipe: directed and small random checks of add_pipe at 32/8, 32/32 and 8/1.
// Expected overflow sums follow ADD_PIPE_SAT_EN when it is defined.
module tb_add_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

`ifdef ADD_PIPE_SAT_EN
  localparam logic [31:0] OVF_POS = 32'h7FFF_FFFF;
  localparam logic [31:0] OVF_NEG = 32'h8000_0000;
  localparam bit          SAT     = 1'b1;
`else
  localparam logic [31:0] OVF_POS = 32'h8000_0000;
  localparam logic [31:0] OVF_NEG = 32'h7FFF_FFFF;
  localparam bit          SAT     = 1'b0;
`endif

  logic        in_valid0, in_ready0, cin0, sub0, out_valid0, out_ready0, cout0, ovf0;
  logic [31:0] a0, b0, sum0;
  logic        in_valid1, in_ready1, cin1, sub1, out_valid1, out_ready1, cout1, ovf1;
  logic [31:0] a1, b1, sum1;
  logic        in_valid2, in_ready2, cin2, sub2, out_valid2, out_ready2, cout2, ovf2;
  logic [7:0]  a2, b2, sum2;

  add_pipe #(.WIDTH(32), .CHUNK(8)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0), .a(a0), .b(b0),
    .cin(cin0), .sub(sub0), .out_valid(out_valid0), .out_ready(out_ready0), .sum(sum0),
    .cout(cout0), .ovf(ovf0));
  add_pipe #(.WIDTH(32), .CHUNK(32)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .a(a1), .b(b1),
    .cin(cin1), .sub(sub1), .out_valid(out_valid1), .out_ready(out_ready1), .sum(sum1),
    .cout(cout1), .ovf(ovf1));
  add_pipe #(.WIDTH(8), .CHUNK(1)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .a(a2), .b(b2),
    .cin(cin2), .sub(sub2), .out_valid(out_valid2), .out_ready(out_ready2), .sum(sum2),
    .cout(cout2), .ovf(ovf2));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: {ovf, cout, sum} straight from the arithmetic definition, w-bit result.
  function automatic logic [33:0] ref_op(input int w, input logic [31:0] a, input logic [31:0] b,
                                         input logic cin, input logic sub);
    logic [63:0] mask, msb, a64, be, full, s;
    logic        ov, co, am;
    mask = (64'd1 << w) - 64'd1;
    msb  = 64'd1 << (w - 1);
    a64  = {32'd0, a};
    be   = sub ? (~{32'd0, b} & mask) : {32'd0, b};
    full = a64 + be + {63'd0, cin ^ sub};
    s    = full & mask;
    co   = full[w];
    am   = (a64 & msb) != 64'd0;
    ov   = (am == ((be & msb) != 64'd0)) && (((s & msb) != 64'd0) != am);
    if (SAT && ov) s = am ? msb : msb - 64'd1;
    return {ov, co, s[31:0]};
  endfunction

  // Single op on dut0 with out_ready high; caller sits 1 time unit after a rising edge.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic cin, input logic sub, input logic [31:0] e_sum,
                        input logic e_cout, input logic e_ovf);
    int lat;
    a0 = a; b0 = b; cin0 = cin; sub0 = sub; in_valid0 = 1'b1; out_ready0 = 1'b1;
    lat = 0;
    for (int c = 1; c <= 20 && lat == 0; c++) begin
      @(posedge clk); #1;
      in_valid0 = 1'b0;
      if (out_valid0) lat = c;
    end
    check({tag, " latency"}, 64'(lat), 64'd4);
    check({tag, " sum"}, 64'(sum0), 64'(e_sum));
    check({tag, " cout"}, 64'(cout0), 64'(e_cout));
    check({tag, " ovf"}, 64'(ovf0), 64'(e_ovf));
  endtask

  logic [33:0] exp_q[$];
  logic [33:0] q1[$];
  logic [33:0] q2[$];
  logic [33:0] held, e;
  int          sent, got, first1, first2, n1, n2, wait_c;
  logic        stall_prev, acc, seen;

  initial begin
    rst = 1'b1;
    in_valid0 = 0; a0 = '0; b0 = '0; cin0 = 0; sub0 = 0; out_ready0 = 1;
    in_valid1 = 0; a1 = '0; b1 = '0; cin1 = 0; sub1 = 0; out_ready1 = 1;
    in_valid2 = 0; a2 = '0; b2 = '0; cin2 = 0; sub2 = 0; out_ready2 = 1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    check("reset out_valid", 64'(out_valid0), 64'd0);
    check("reset sum", 64'(sum0), 64'd0);
    check("reset cout", 64'(cout0), 64'd0);
    check("reset ovf", 64'(ovf0), 64'd0);
    check("reset in_ready", 64'(in_ready0), 64'd1);

    run_op("lat", 32'h0000_00FF, 32'h0000_0001, 0, 0, 32'h0000_0100, 0, 0);
    run_op("carry_chain", 32'hFFFF_FFFF, 32'h0, 1, 0, 32'h0, 1, 0);
    run_op("wrap", 32'hFFFF_FFFF, 32'h1, 0, 0, 32'h0, 1, 0);
    run_op("sub_5_7", 32'd5, 32'd7, 0, 1, 32'hFFFF_FFFE, 0, 0);
    run_op("sub_borrow", 32'd10, 32'd3, 1, 1, 32'd6, 1, 0);
    run_op("chunk_carry", 32'h00FF_FFFF, 32'h1, 0, 0, 32'h0100_0000, 0, 0);
    run_op("ovf_pos", 32'h7FFF_FFFF, 32'h1, 0, 0, OVF_POS, 0, 1);
    run_op("ovf_neg", 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, OVF_NEG, 1, 1);
    run_op("ovf_sub", 32'h8000_0000, 32'h1, 0, 1, OVF_NEG, 1, 1);
    run_op("mixed", 32'h1234_5678, 32'h0FED_CBA9, 1, 0, 32'h2222_2222, 0, 0);

    // Directed stall: result must hold and input must be refused.
    in_valid0 = 0; out_ready0 = 1;
    @(posedge clk); #1;
    a0 = 32'd1; b0 = 32'd2; cin0 = 0; sub0 = 0; in_valid0 = 1; out_ready0 = 0;
    wait_c = 0;
    while (!out_valid0 && wait_c < 20) begin
      @(posedge clk); #1;
      in_valid0 = 0;
      wait_c++;
    end
    check("stall arrive", 64'(wait_c), 64'd4);
    for (int i = 0; i < 3; i++) begin
      check("stall out_valid", 64'(out_valid0), 64'd1);
      check("stall sum", 64'(sum0), 64'd3);
      check("stall in_ready", 64'(in_ready0), 64'd0);
      @(posedge clk); #1;
    end
    out_ready0 = 1;
    @(posedge clk); #1;
    check("stall release", 64'(out_valid0), 64'd0);

    // Random backpressure stream of 10 ops.
    sent = 0; got = 0; stall_prev = 0; held = '0;
    a0 = $urandom; b0 = $urandom; cin0 = 1'($urandom_range(0, 1)); sub0 = 1'($urandom_range(0, 1));
    for (int cyc = 0; cyc < 300 && got < 10; cyc++) begin
      in_valid0  = (sent < 10);
      out_ready0 = 1'($urandom_range(0, 1));
      #1;
      check("bp in_ready", 64'(in_ready0), 64'(!out_valid0 || out_ready0));
      if (stall_prev) check("bp hold", {30'd0, out_valid0, ovf0, cout0, sum0}, {30'd0, 1'b1, held});
      if (out_valid0 && out_ready0) begin
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        check("bp result", {30'd0, ovf0, cout0, sum0}, {30'd0, e});
        got++;
      end
      acc = in_valid0 && in_ready0;
      if (acc) begin
        exp_q.push_back(ref_op(32, a0, b0, cin0, sub0));
        sent++;
      end
      stall_prev = out_valid0 && !out_ready0;
      held = {ovf0, cout0, sum0};
      @(posedge clk); #1;
      if (acc) begin
        a0 = $urandom; b0 = $urandom;
        cin0 = 1'($urandom_range(0, 1)); sub0 = 1'($urandom_range(0, 1));
      end
    end
    in_valid0 = 0;
    check("bp count", 64'(got), 64'd10);

    // Reset with three ops in flight; none may emerge.
    out_ready0 = 1;
    for (int i = 0; i < 3; i++) begin
      a0 = 32'(i + 1); b0 = 32'h100; cin0 = 0; sub0 = 0; in_valid0 = 1;
      @(posedge clk); #1;
    end
    in_valid0 = 0; rst = 1;
    @(posedge clk); #1;
    rst = 0;
    check("rst out_valid", 64'(out_valid0), 64'd0);
    check("rst sum", 64'(sum0), 64'd0);
    check("rst flags", {62'd0, cout0, ovf0}, 64'd0);
    check("rst in_ready", 64'(in_ready0), 64'd1);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (out_valid0 || sum0 != 32'd0) seen = 1;
    end
    check("rst flushed", 64'(seen), 64'd0);
    run_op("post_rst", 32'hABCD_0000, 32'h0000_1234, 0, 0, 32'hABCD_1234, 0, 0);

    // Parameter sweep: 32/32 (latency 1) and 8/1 (latency 8), streaming.
    first1 = -1; first2 = -1; n1 = 0; n2 = 0;
    for (int it = 0; it < 215; it++) begin
      if (out_valid1) begin
        if (first1 < 0) first1 = it;
        e = (q1.size() != 0) ? q1.pop_front() : 'x;
        check("sw32 result", {30'd0, ovf1, cout1, sum1}, {30'd0, e});
        n1++;
      end
      if (out_valid2) begin
        if (first2 < 0) first2 = it;
        e = (q2.size() != 0) ? q2.pop_front() : 'x;
        check("sw8 result", {30'd0, ovf2, cout2, 24'd0, sum2}, {30'd0, e});
        n2++;
      end
      if (it < 200) begin
        a1 = $urandom; b1 = $urandom;
        cin1 = 1'($urandom_range(0, 1)); sub1 = 1'($urandom_range(0, 1)); in_valid1 = 1;
        q1.push_back(ref_op(32, a1, b1, cin1, sub1));
        a2 = 8'($urandom_range(0, 255)); b2 = 8'($urandom_range(0, 255));
        cin2 = 1'($urandom_range(0, 1)); sub2 = 1'($urandom_range(0, 1)); in_valid2 = 1;
        q2.push_back(ref_op(8, {24'd0, a2}, {24'd0, b2}, cin2, sub2));
      end else begin
        in_valid1 = 0; in_valid2 = 0;
      end
      @(posedge clk); #1;
    end
    check("sw32 latency", 64'(first1), 64'd1);
    check("sw8 latency", 64'(first2), 64'd8);
    check("sw32 count", 64'(n1), 64'd200);
    check("sw8 count", 64'(n2), 64'd200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/add_pipe.md
Name: add_pipe

Overview:
- Parametrised, pipelined two's-complement adder/subtractor; successor to the fixed 8-bit combinational ripple adder.
- Splits a WIDTH-bit add into WIDTH/CHUNK carry-registered stages.
- Accepts one operation per cycle through a valid/ready handshake at each end.
- Sits between operand producers and result consumers in the datapath; also gives carry-out and signed-overflow flags.

Parameters:
- WIDTH, 32, operand and result width in bits; must be a multiple of CHUNK.
- CHUNK, 8, bits summed per pipeline stage; 1 <= CHUNK <= WIDTH.
- Derived, not overridable: STAGES = WIDTH/CHUNK.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand set on a/b/cin/sub is valid.
- in_ready  output  1  block accepts the operand set this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in (sub=0) or borrow-in (sub=1).
- sub  input  1  0: add; 1: subtract.
- out_valid  output  1  result on sum/cout/ovf is valid.
- out_ready  input  1  consumer takes the result this cycle.
- sum  output  WIDTH  result, low WIDTH bits.
- cout  output  1  carry out of the MSB; for sub, 1 means no borrow.
- ovf  output  1  signed overflow.

Behaviour:
- Arithmetic:
  - sub=0: {cout,sum} = a + b + cin.
  - sub=1: {cout,sum} = a + ~b + (1 - cin), i.e. a - b - cin.
  - ovf = (a[MSB] == b_eff[MSB]) && (sum[MSB] != a[MSB]), where b_eff is b, or ~b when sub=1.
- Pipeline structure:
  - Stage k (k = 0..STAGES-1) adds chunk k of a and b_eff using the carry registered out of stage k-1.
  - Stage 0 uses the effective carry-in.
  - Upper operand chunks are delayed (skewed) until their stage.
  - Lower result chunks are delayed (deskewed) so all of sum appears together.
- Global advance: en = !out_valid || out_ready.
  - in_ready = en; this is combinational from out_valid and out_ready only, not from in_valid.
  - When en=1, every stage register, including its valid bit, shifts one stage.
  - When en=0, all stages hold.
  - Bubbles are not collapsed.
- Transfers:
  - Transfer in: in_valid && in_ready.
  - Transfer out: out_valid && out_ready.
- Latency: exactly STAGES cycles from accept to out_valid when never stalled. STAGES=1 gives a registered single-cycle adder.
- Throughput: one result per cycle while out_ready stays high.
- Output stability: while out_valid=1 and out_ready=0, sum, cout and ovf hold stable and no input is accepted.
- A simultaneous accept and output transfer in the same cycle is legal and is the steady-state case.
- Wrap-around: sum is modulo 2^WIDTH. Example: 0xFFFFFFFF + 1 gives sum=0, cout=1, ovf=0.
- Reset:
  - All stage valid bits clear.
  - out_valid=0, sum=0, cout=0, ovf=0.
  - in_ready=1 from the first cycle after reset.
  - Operations in flight when rst is asserted are discarded; none reach the output.
- Data contents of invalid stages are don't-care internally. Outputs must still read 0 after reset until the first valid result.

Optional Feature:
- Macro: ADD_PIPE_SAT_EN.
- Defined: sum saturates in signed interpretation.
  - On ovf=1 with a[MSB]=0, sum = 2^(WIDTH-1)-1.
  - On ovf=1 with a[MSB]=1, sum = -2^(WIDTH-1).
  - ovf is still reported; cout is unchanged.
  - The clamp is applied in the final stage and adds no latency.
- Undefined: sum wraps as specified above; no clamp logic is present.

Test Plan (WIDTH=32, CHUNK=8 unless stated):
- Latency: one accept a=0x000000FF, b=0x00000001, cin=0, sub=0, out_ready=1 -> out_valid exactly 4 cycles later; sum=0x00000100, cout=0, ovf=0.
- Full carry chain: a=0xFFFFFFFF, b=0, cin=1 -> sum=0, cout=1. Then sub=1, a=5, b=7, cin=0 -> sum=0xFFFFFFFE, cout=0.
- Overflow: a=0x7FFFFFFF, b=1, add -> sum=0x80000000, ovf=1. With ADD_PIPE_SAT_EN: sum=0x7FFFFFFF, ovf=1.
- Backpressure: stream 10 random ops back-to-back while toggling out_ready randomly -> in_ready==(!out_valid||out_ready) every cycle; outputs held while stalled; all 10 results in order and equal to the reference model.
- Reset mid-flight: accept 3 ops, assert rst for 1 cycle at cycle 2 -> no out_valid ever for those ops; outputs 0; a new op after reset appears 4 cycles after its accept.
- Parameter sweep: CHUNK=32 (latency 1), CHUNK=1 with WIDTH=8 (latency 8), 200 random ops each -> match the reference model bit-exactly.
